// File: rtl/status_ctrl.sv
// status_ctrl
//   Front end for the LED pattern status FSM. Synchronises and debounces the
//   three raw active-low KEY buttons, turns debounced presses into one-cycle
//   events, and runs a small IDLE/RUN/PAUSED control FSM that issues start and
//   pause pulses plus an active-low step strobe (manual or auto-timed in RUN).
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-high reset
//   key_step_n   raw step button, active-low, asynchronous
//   key_start_n  raw start button, active-low, asynchronous
//   key_pause_n  raw pause button, active-low, asynchronous
//   auto_en      1 = generate auto-step strobes while in RUN
//   in           step strobe, active-low, one-cycle low pulse
//   start        one-cycle high pulse on accepted start
//   pause        one-cycle high pulse on accepted pause
//   run          1 while the control FSM is in RUN
//   ctrl_state   0=IDLE 1=RUN 2=PAUSED
module status_ctrl #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned AUTO_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_step_n,
    input  logic       key_start_n,
    input  logic       key_pause_n,
    input  logic       auto_en,
    output logic       in,
    output logic       start,
    output logic       pause,
    output logic       run,
    output logic [1:0] ctrl_state
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned AUTO_W = $clog2(AUTO_DIV);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);

    localparam int unsigned KEY_STEP  = 0;
    localparam int unsigned KEY_START = 1;
    localparam int unsigned KEY_PAUSE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    logic [2:0]             keys_raw;
    logic [2:0]             sync1_q, sync2_q;
    logic [2:0]             deb_q, deb_d;
    logic [2:0]             evt_q, evt_d;
    logic [2:0][DEB_W-1:0]  dcnt_q, dcnt_d;

    state_e                 state_q, state_d;
    logic                   start_acc, pause_acc;
    logic                   auto_adv, auto_tick;
    logic [AUTO_W-1:0]      acnt_q, acnt_d;
    logic                   in_q, in_d;
    logic                   start_q, start_d;
    logic                   pause_q, pause_d;

    assign keys_raw = {key_pause_n, key_start_n, key_step_n};

    // ---------------- synchroniser + debounce + press events ----------------
    // The event is registered on the same edge the debounced level falls, so
    // the output registers below present it one edge later (DEB_CYCLES+3).
    always_comb begin
        deb_d  = deb_q;
        evt_d  = '0;
        dcnt_d = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (sync2_q[k] != deb_q[k]) begin
                if (dcnt_q[k] == DEB_LAST) begin
                    deb_d[k] = sync2_q[k];
                    evt_d[k] = ~sync2_q[k];
                end else begin
                    dcnt_d[k] = dcnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            evt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            evt_q   <= evt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // ---------------- control FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- control FSM: next state ----------------
    // Pause outranks start when both events land in the same cycle.
    always_comb begin
        pause_acc = evt_q[KEY_PAUSE] && (state_q == ST_RUN);
        start_acc = evt_q[KEY_START] && !evt_q[KEY_PAUSE] && (state_q != ST_RUN);
        state_d   = state_q;
        case (state_q)
            ST_IDLE:   if (start_acc) state_d = ST_RUN;
            ST_RUN:    if (pause_acc) state_d = ST_PAUSED;
            ST_PAUSED: if (start_acc) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- control FSM: outputs + auto-step counter ----------------
    // The counter freezes on the RUN->PAUSED edge so a resume continues from
    // exactly the value seen when the pause was accepted.
    always_comb begin
        auto_adv  = (state_q == ST_RUN) && auto_en && !pause_acc;
        auto_tick = auto_adv && (acnt_q == AUTO_LAST);
        acnt_d    = acnt_q;
        if (start_acc && (state_q != ST_PAUSED)) begin
            acnt_d = '0;
        end else if (auto_adv) begin
            acnt_d = auto_tick ? '0 : acnt_q + 1'b1;
        end
        in_d    = ~(evt_q[KEY_STEP] | auto_tick);
        start_d = start_acc;
        pause_d = pause_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acnt_q  <= '0;
            in_q    <= 1'b1;
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            acnt_q  <= acnt_d;
            in_q    <= in_d;
            start_q <= start_d;
            pause_q <= pause_d;
        end
    end

    assign in         = in_q;
    assign start      = start_q;
    assign pause      = pause_q;
    assign run        = (state_q == ST_RUN);
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_status_ctrl.sv
// tb_status_ctrl
//   Directed bench for status_ctrl (DEB_CYCLES=4, AUTO_DIV=8). A behavioural
//   model tracks key stability runs, press events and the control/auto-step
//   rules; a compare process checks every output each falling edge, and the
//   directed sequence pins exact pulse timing with literal expectations.
module tb_status_ctrl;

    localparam int DEB  = 4;
    localparam int ADIV = 8;

    logic       clk;
    logic       reset;
    logic [2:0] keys_n;        // [0]=step [1]=start [2]=pause
    logic       auto_en;
    logic       in, start, pause, run;
    logic [1:0] ctrl_state;

    status_ctrl #(.DEB_CYCLES(DEB), .AUTO_DIV(ADIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_step_n (keys_n[0]),
        .key_start_n(keys_n[1]),
        .key_pause_n(keys_n[2]),
        .auto_en    (auto_en),
        .in         (in),
        .start      (start),
        .pause      (pause),
        .run        (run),
        .ctrl_state (ctrl_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    int   m_hist1[3], m_hist2[3];  // raw level seen one and two edges ago
    int   m_deb[3], m_run[3], m_evt[3], new_evt[3];
    int   m_state, m_cnt;
    logic m_in, m_start, m_pause;
    bit   stp, sta, pau, pa_ok, st_ok, tick;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                m_hist1[k] = 1; m_hist2[k] = 1; m_deb[k] = 1; m_run[k] = 0; m_evt[k] = 0;
            end
            m_state = 0; m_cnt = 0; m_in = 1; m_start = 0; m_pause = 0;
        end else begin
            stp   = m_evt[0] != 0;
            sta   = m_evt[1] != 0;
            pau   = m_evt[2] != 0;
            pa_ok = pau && m_state == 1;
            st_ok = sta && !pau && m_state != 1;
            tick  = m_state == 1 && auto_en && !pa_ok && m_cnt == ADIV - 1;
            m_in    = !(stp || tick);
            m_start = st_ok;
            m_pause = pa_ok;
            if (st_ok && m_state == 0) m_cnt = 0;
            else if (m_state == 1 && auto_en && !pa_ok) m_cnt = (m_cnt + 1) % ADIV;
            if (pa_ok) m_state = 2;
            else if (st_ok) m_state = 1;
            for (int k = 0; k < 3; k++) begin
                new_evt[k] = 0;
                if (m_hist2[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_deb[k]   = m_hist2[k];
                        m_run[k]   = 0;
                        new_evt[k] = (m_deb[k] == 0);
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_hist2[k] = m_hist1[k];
                m_hist1[k] = int'(keys_n[k]);
                m_evt[k]   = new_evt[k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in",         in,         m_in);
            chk("start",      start,      m_start);
            chk("pause",      pause,      m_pause);
            chk("run",        run,        m_state == 1);
            chk("ctrl_state", ctrl_state, m_state[1:0]);
        end
    end

    // ---------------- directed stimulus ----------------
    int lo_cnt, lo_first, lo_last, st_cnt, st_first, pa_cnt, pa_first;
    logic [1:0] st_last;

    // Observe n falling edges; index i means "after the i-th rising edge".
    task automatic watch(input int n, input logic [2:0] rel_mask, input int rel_at);
        lo_cnt = 0; lo_first = 0; lo_last = 0;
        st_cnt = 0; st_first = 0; pa_cnt = 0; pa_first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (in === 1'b0) begin
                lo_cnt++; lo_last = i;
                if (lo_first == 0) lo_first = i;
            end
            if (start === 1'b1) begin
                st_cnt++;
                if (st_first == 0) st_first = i;
            end
            if (pause === 1'b1) begin
                pa_cnt++;
                if (pa_first == 0) pa_first = i;
            end
            if (i == rel_at) keys_n = keys_n | rel_mask;
        end
        st_last = ctrl_state;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; reset = 0; keys_n = 3'b111; auto_en = 0;

        // T1: async reset visible before any clock edge
        #2 reset = 1;
        #1;
        chk("t1_in", in, 1);
        chk("t1_start", start, 0);
        chk("t1_pause", pause, 0);
        chk("t1_run", run, 0);
        chk("t1_state", ctrl_state, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        chk_en = 1;

        // T2: glitch of DEB-1 cycles ignored; held press gives one strobe at edge 7
        keys_n[0] = 0;
        repeat (3) @(negedge clk);
        keys_n[0] = 1;
        watch(10, 3'b000, 0);
        chk("t2_glitch_lows", lo_cnt, 0);
        keys_n[0] = 0;
        watch(20, 3'b000, 0);
        chk("t2_held_lows", lo_cnt, 1);
        chk("t2_held_edge", lo_first, 7);
        keys_n[0] = 1;
        watch(12, 3'b000, 0);
        chk("t2_release_lows", lo_cnt, 0);

        // T3: auto mode, start from IDLE, strobes every 8 edges
        auto_en = 1;
        keys_n[1] = 0;
        watch(32, 3'b010, 10);
        chk("t3_start_cnt", st_cnt, 1);
        chk("t3_start_edge", st_first, 7);
        chk("t3_state", st_last, 1);
        chk("t3_lows", lo_cnt, 3);
        chk("t3_first_strobe", lo_first, 15);
        chk("t3_last_strobe", lo_last, 31);

        // T4: pause lands with auto count 5, then resume
        repeat (6) @(negedge clk);
        keys_n[2] = 0;
        watch(60, 3'b100, 10);
        chk("t4_pause_cnt", pa_cnt, 1);
        chk("t4_pause_edge", pa_first, 7);
        chk("t4_lows", lo_cnt, 1);
        chk("t4_last_low", lo_last, 1);
        chk("t4_state", st_last, 2);
        keys_n[1] = 0;
        watch(12, 3'b010, 10);
        chk("t4_resume_start", st_first, 7);
        chk("t4_resume_strobe", lo_first, 10);
        chk("t4_resume_lows", lo_cnt, 1);
        chk("t4_resume_state", st_last, 1);

        // T5: simultaneous start+pause in RUN, then in PAUSED
        keys_n[2:1] = 2'b00;
        watch(14, 3'b110, 10);
        chk("t5_run_start_cnt", st_cnt, 0);
        chk("t5_run_pause_cnt", pa_cnt, 1);
        chk("t5_run_pause_edge", pa_first, 7);
        chk("t5_run_state", st_last, 2);
        chk("t5_run_strobe", lo_first, 6);
        keys_n[2:1] = 2'b00;
        watch(14, 3'b110, 10);
        chk("t5_psd_start_cnt", st_cnt, 0);
        chk("t5_psd_pause_cnt", pa_cnt, 0);
        chk("t5_psd_state", st_last, 2);
        chk("t5_psd_lows", lo_cnt, 0);

        // T5b: step press coinciding with the auto wrap gives one low cycle
        keys_n[1] = 0;
        watch(12, 3'b010, 10);
        chk("t5_resume_state", st_last, 1);
        repeat (4) @(negedge clk);
        keys_n[0] = 0;
        watch(16, 3'b001, 10);
        chk("t5_coin_lows", lo_cnt, 2);
        chk("t5_coin_first", lo_first, 7);
        chk("t5_coin_next", lo_last, 15);

        // T6: reset during RUN with step key mid-debounce
        auto_en = 0;
        keys_n[0] = 0;
        repeat (3) @(negedge clk);
        chk("t6_pre_run", run, 1);
        #2 reset = 1;
        #1;
        chk("t6_in", in, 1);
        chk("t6_start", start, 0);
        chk("t6_pause", pause, 0);
        chk("t6_run", run, 0);
        chk("t6_state", ctrl_state, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        watch(20, 3'b000, 0);
        chk("t6_held_lows", lo_cnt, 1);
        chk("t6_held_edge", lo_first, 7);
        keys_n[0] = 1;
        watch(8, 3'b000, 0);
        chk("t6_release_lows", lo_cnt, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
